cnt_mod_updown: RTL
===================

// Module: cnt_mod_updown
// PURPOSE
//   Parametrised synchronous up/down counter, successor to the 4-bit loadable binary counter.
//   Adds configurable width and modulus, count direction, synchronous clear and saturate mode.
//   Keeps the CET/CEP/TC cascade scheme, so multi-stage counters chain without glue logic.
//   Used as a general timer/prescaler and event-counter stage across the design.
// PARAMETERS
//   WIDTH     4    counter width in bits; legal range 2..16
//   MODULUS   16   count range 0..MODULUS-1; legal range 2..2**WIDTH
//   SATURATE  0    0 = wrap at either end, 1 = hold at the end value
// PORTS
//   CP     in   1      clock; all state changes on the rising edge
//   MR     in   1      master reset, asynchronous, active-high
//   SR     in   1      synchronous clear, active-low
//   PE     in   1      parallel load enable, active-low, synchronous
//   CEP    in   1      count enable, parallel
//   CET    in   1      count enable, trickle; also gates TC
//   UD     in   1      direction: 1 = up, 0 = down
//   P      in   WIDTH  parallel load data
//   Q      out  WIDTH  counter value, registered
//   TC     out  1      terminal count, combinational
//   WRAP   out  1      registered one-cycle pulse on wrap-around
// BEHAVIOUR
//   - MAX = MODULUS-1. Q is never outside 0..MAX.
//   - MR=1 at any time forces Q=0 and WRAP=0 immediately, with no clock needed.
//     The counter leaves reset on the first CP rising edge after MR falls.
//   - Per-edge priority, highest first (MR=0 assumed):
//     1. SR=0: Q<=0, WRAP<=0.
//     2. PE=0: Q<=P, or Q<=MAX if P>MAX. WRAP<=0. Load ignores CET, CEP and UD.
//     3. CET&CEP=1 and UD=1:
//        - Q<MAX: Q<=Q+1.
//        - Q==MAX, SATURATE=0: Q<=0, WRAP<=1.
//        - Q==MAX, SATURATE=1: Q holds.
//     4. CET&CEP=1 and UD=0:
//        - Q>0: Q<=Q-1.
//        - Q==0, SATURATE=0: Q<=MAX, WRAP<=1.
//        - Q==0, SATURATE=1: Q holds.
//     5. Otherwise Q holds.
//   - WRAP is 0 on every edge where it is not explicitly set to 1.
//   - WRAP is never 1 when SATURATE=1.
//   - Enables are applied on the same edge they are sampled: zero added latency. No internal pipeline register.
//   - TC = CET & (UD ? Q==MAX : Q==0). TC is independent of CEP, PE and SR.
//   - TC is 0 while MR=1 and UD=1. TC is 1 while MR=1, UD=0 and CET=1, because Q=0.
//   - Cascading: stage N+1 CET = stage N TC, and all stages share CEP.
//   - Changing UD between edges takes effect on the next edge. TC re-evaluates combinationally.
//   - Arithmetic is done modulo MODULUS, never modulo 2**WIDTH. Q+1 and Q-1 never overflow the WIDTH-bit range.
//   - MR asserted mid-count discards the in-flight value. There is no glitch on Q except the async clear itself.
//   - Out-of-range parameters (MODULUS>2**WIDTH or MODULUS<2) are reported at elaboration with $error.
// TESTING
//   Defaults, MR pulse 1->0; 20 edges, CET=CEP=UD=1
//     -> Q steps 0..15, then 0..3; WRAP=1 exactly one cycle after the 15->0 edge.
//   WIDTH=4, MODULUS=10, UD=0, load P=3, then count
//     -> 3,2,1,0,9,8; TC=1 only while Q=0 and CET=1.
//   MODULUS=10, SATURATE=1, load P=12, count up 3 edges
//     -> Q=9 after load and stays 9; TC=1; WRAP never asserted.
//   Q=7, CEP=1, CET=0 for 3 edges, then PE=0 and SR=0 on the same edge
//     -> Q holds 7, then Q=0 (SR wins); TC=0 throughout.
//   Two cascaded defaults (TC0->CET1), 40 edges
//     -> {Q1,Q0} counts 0..39 in binary; stage 1 increments only on Q0=15 edges.
//   MR raised mid-cycle at Q=5, with no clock edge
//     -> Q=0 and WRAP=0 immediately; counting resumes from 0 after MR falls.

Source files
------------

// File: rtl/cnt_mod_updown.sv
// cnt_mod_updown
//   Parametrised synchronous up/down counter with a programmable modulus, an
//   optional saturate mode, a synchronous clear and a parallel load. It keeps
//   the CET/CEP/TC cascade scheme, so stages chain with no extra logic:
//   CET of stage N+1 is driven by TC of stage N, and all stages share CEP.
//
// Parameters
//   WIDTH     counter width in bits (2..16)
//   MODULUS   count range 0..MODULUS-1 (2..2**WIDTH)
//   SATURATE  0 = wrap at either end, 1 = hold at the end value
//
// Ports
//   CP    in   clock, rising edge
//   MR    in   master reset, asynchronous, active-high
//   SR    in   synchronous clear, active-low
//   PE    in   parallel load enable, active-low
//   CEP   in   count enable, parallel
//   CET   in   count enable, trickle (also gates TC)
//   UD    in   direction, 1 = up, 0 = down
//   P     in   parallel load data
//   Q     out  registered count value, always within 0..MODULUS-1
//   TC    out  terminal count, combinational
//   WRAP  out  registered one-cycle pulse on wrap-around
module cnt_mod_updown #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             SR,
    input  logic             PE,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UD,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("cnt_mod_updown: WIDTH=%0d outside 2..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("cnt_mod_updown: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    // Loaded values above the modulus are clamped so Q never leaves 0..MAX.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX) ? MAX : v;
    endfunction

    // The end value is compared explicitly rather than relying on WIDTH-bit
    // overflow, so arithmetic is modulo MODULUS, not 2**WIDTH.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        return (v == MAX) ? (SATURATE ? MAX : ZERO) : v + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        return (v == ZERO) ? (SATURATE ? ZERO : MAX) : v - ONE;
    endfunction

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (!SR) begin
            q_d = ZERO;
        end else if (!PE) begin
            q_d = clamp_load(P);
        end else if (CET && CEP) begin
            if (UD) begin
                q_d    = step_up(q_q);
                wrap_d = !SATURATE && (q_q == MAX);
            end else begin
                q_d    = step_down(q_q);
                wrap_d = !SATURATE && (q_q == ZERO);
            end
        end
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            q_q    <= ZERO;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign WRAP = wrap_q;
    assign TC   = CET & (UD ? (q_q == MAX) : (q_q == ZERO));

endmodule
